axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream (read or write, one 32-bit word) into AXI4-Lite transactions and returns one response per command. It sits directly upstream of the team's AXI4-Lite SRAM slave and drives all of that slave's AW/W/B/AR/R channels. Misaligned and out-of-range commands are rejected locally and never reach the bus. Per-direction completed-transaction counters support test and debug.

## Interface
- MEM_BYTES, 1024: size of the addressable slave window in bytes; legal range is 0 .. MEM_BYTES-1.
- CNT_W, 16: width of the completion counters.

- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes and for local errors.
- rsp_resp  out  2  BRESP/RRESP from the bus, or the local error code.
- AWADDR/AWVALID/AWREADY, WDATA/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports. Address and data are 32 bits; RESP is 2 bits.
- busy  out  1  high whenever state != IDLE.
- wr_count, rd_count  out  CNT_W  bus writes/reads completed; wrap modulo 2^CNT_W.

## Operation
- FSM states are IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1; no other output asserted. On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata, then branch:
  - cmd_addr[1:0]!=0: go to RSP with rsp_resp=2'b10 (SLVERR).
  - else cmd_addr>=MEM_BYTES: go to RSP with rsp_resp=2'b11 (DECERR).
  - else write: go to WR_REQ.
  - else read: go to RD_REQ.
- WR_REQ: AWVALID=1 and WVALID=1 assert together.
  - AW and W handshakes are tracked with independent done flags; each VALID drops the cycle after its own handshake.
  - AWADDR/WDATA stay stable while the corresponding VALID is high.
  - When both handshakes are done, go to WR_RESP. This includes the case where both complete in the same cycle.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, increment wr_count, go to RSP.
- RD_REQ: ARVALID=1 and ARADDR is held stable. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP, increment rd_count, go to RSP.
- RSP: rsp_valid=1 and the response fields are held stable. On rsp_ready, go to IDLE.
- Non-OKAY bus responses are passed through unchanged. Counters still increment for them.
- Local errors issue no bus activity and do not increment either counter.
- BREADY and RREADY are high only in WR_RESP and RD_DATA respectively.
- Address is forwarded unmodified. The slave decodes addr[9:2].

## Timing
- Reset values: cmd_ready=0 during reset, 1 the cycle after. All other outputs are 0: VALIDs, READYs, rsp_* fields, AWADDR/WDATA/ARADDR, busy, counters. State is IDLE.
- All AXI and rsp outputs are registered or pure state decode. None combinationally depends on a ready/valid input.
- Cycle-level sequences below assume an always-ready slave that responds one cycle after handshake. Cycle 0 is the accept cycle; cmd_ready returns high in cycle 4.
  - Write: AW+W handshake in cycle 1; B handshake in cycle 2; rsp_valid in cycle 3.
  - Read: AR handshake in cycle 1; R handshake in cycle 2; rsp_valid in cycle 3.
- Peak throughput is 1 command per 4 cycles.
- Local error: rsp_valid in cycle 1, cmd_ready high again in cycle 2 if rsp_ready=1.
- Backpressure:
  - rsp_ready low holds RSP indefinitely and cmd_ready stays 0.
  - AWREADY/WREADY/ARREADY low holds the request state with the VALIDs stable.
  - BVALID/RVALID delay holds the wait state.
- No new command is accepted until the response handshake completes. There is exactly one outstanding transaction.
- Reset mid-transaction: return to IDLE next cycle, drop all VALIDs, emit no response, and clear the counters.
- Counter wrap: increment from 2^CNT_W-1 gives 0.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 with rsp_ready=1 → write rsp with rsp_resp=0, then read rsp with rsp_rdata=0xDEADBEEF. Each rsp_valid arrives 3 cycles after its accept. wr_count=1, rd_count=1.
- Read at 0x3FC after a write of 0x12345678 to 0x3FC → rsp_rdata=0x12345678. Read at 0x400 → rsp_resp=2'b11, no ARVALID ever, rd_count unchanged.
- Write to 0x06 → rsp_resp=2'b10 at cycle 1, no AWVALID/WVALID, wr_count unchanged.
- Slave stalls: AWREADY=1 in cycle 1 with WREADY=0 until cycle 4 → AWVALID drops in cycle 2, WVALID stays high through cycle 4, and BREADY first asserts in cycle 5.
- rsp_ready held 0 for 10 cycles after a read → rsp_valid and rsp_rdata stay stable, cmd_ready stays 0, and a pending cmd_valid is not accepted until after the rsp handshake.
- ARESETn pulsed low while in RD_DATA → all VALIDs 0, busy=0, no rsp_valid. The next command completes normally. With CNT_W=2, 5 writes give wr_count=1.

Source files
------------

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite master fed by a read/write command stream
module axil_cmd_master #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [31:0]       cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [31:0]       AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // AXI4-Lite read address / data
  output logic [31:0]       ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  // status
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_write_q, rsp_write_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  logic accept;
  logic misaligned;
  logic out_of_range;
  logic aw_hs;
  logic w_hs;

  // cmd_ready is a flop, so acceptance only looks at the registered ready
  assign accept       = cmd_valid && cmd_ready_q;
  assign misaligned   = (cmd_addr[1:0] != 2'b00);
  assign out_of_range = (cmd_addr >= 32'(MEM_BYTES));
  assign aw_hs        = AWVALID && AWREADY;
  assign w_hs         = WVALID && WREADY;

  // state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; the write request leaves only once both AW and W have completed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned || out_of_range) begin
            state_d = S_RSP;
          end else if (cmd_write) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (BVALID) begin
          state_d = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (ARREADY) begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (RVALID) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bus and response handshake outputs are pure decodes of state and done flags
  always_comb begin
    AWVALID   = (state_q == S_WR_REQ) && !aw_done_q;
    WVALID    = (state_q == S_WR_REQ) && !w_done_q;
    BREADY    = (state_q == S_WR_RESP);
    ARVALID   = (state_q == S_RD_REQ);
    RREADY    = (state_q == S_RD_DATA);
    rsp_valid = (state_q == S_RSP);
    busy      = (state_q != S_IDLE);
  end

  // datapath: latch command, track AW/W completion, capture bus response, count completions
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_write_d = cmd_write;
          rsp_rdata_d = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (misaligned) begin
            rsp_resp_d = RESP_SLVERR;
          end else if (out_of_range) begin
            rsp_resp_d = RESP_DECERR;
          end else begin
            rsp_resp_d = RESP_OKAY;
          end
        end
      end
      S_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
      end
      S_WR_RESP: begin
        if (BVALID) begin
          rsp_resp_d = BRESP;
          wr_count_d = wr_count_q + CNT_W'(1);
        end
      end
      S_RD_DATA: begin
        if (RVALID) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rd_count_d  = rd_count_q + CNT_W'(1);
        end
      end
      S_RSP: begin
        // clear the response fields once consumed so IDLE shows nothing stale
        if (rsp_ready) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cmd_ready_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - self-checking bench for axil_cmd_master with an SRAM slave model
module tb_axil_cmd_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;
  logic [15:0] wr_count, rd_count;

  // second instance with 2-bit counters shares every input; only its counters are inspected
  logic        u2_cmd_ready, u2_rsp_valid, u2_rsp_write, u2_busy;
  logic [31:0] u2_rsp_rdata, u2_awaddr, u2_wdata, u2_araddr;
  logic [1:0]  u2_rsp_resp;
  logic        u2_awvalid, u2_wvalid, u2_bready, u2_arvalid, u2_rready;
  logic [1:0]  u2_wr_count, u2_rd_count;

  axil_cmd_master #(.MEM_BYTES(1024), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count)
  );

  axil_cmd_master #(.MEM_BYTES(1024), .CNT_W(2)) u2 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(u2_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(u2_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(u2_rsp_write),
    .rsp_rdata(u2_rsp_rdata), .rsp_resp(u2_rsp_resp),
    .AWADDR(u2_awaddr), .AWVALID(u2_awvalid), .AWREADY(AWREADY),
    .WDATA(u2_wdata), .WVALID(u2_wvalid), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(u2_bready),
    .ARADDR(u2_araddr), .ARVALID(u2_arvalid), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(u2_rready),
    .busy(u2_busy), .wr_count(u2_wr_count), .rd_count(u2_rd_count)
  );

  // ---------------- slave model (drives its outputs at the falling edge) ----------------
  logic [31:0] smem [256];
  int          aw_hold = 0, w_hold = 0, ar_hold = 0, b_delay = 0, r_delay = 0;
  logic        rnd = 1'b0;
  logic [1:0]  slv_resp = 2'b00;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  int          b_wait = 0, r_wait = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;

  initial for (int i = 0; i < 256; i++) smem[i] = '0;

  function automatic logic coin();
    return rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
      BVALID = 1'b0; RVALID = 1'b0; BRESP = '0; RRESP = '0; RDATA = '0;
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      BVALID = b_pend && (b_wait == 0);
      BRESP  = BVALID ? slv_resp : 2'b00;
      if (BVALID && BREADY) b_pend = 1'b0;
      else if (b_pend && b_wait > 0) b_wait--;

      if (AWVALID && !aw_got && aw_hold > 0) begin AWREADY = 1'b0; aw_hold--; end
      else AWREADY = coin();
      if (WVALID && !w_got && w_hold > 0) begin WREADY = 1'b0; w_hold--; end
      else WREADY = coin();
      if (AWVALID && AWREADY) begin aw_got = 1'b1; s_awaddr = AWADDR; aw_hs_n++; end
      if (WVALID && WREADY) begin w_got = 1'b1; s_wdata = WDATA; w_hs_n++; end
      if (aw_got && w_got) begin
        if (slv_resp == 2'b00) smem[s_awaddr[9:2]] = s_wdata;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
        b_wait = rnd ? int'($urandom_range(0, 2)) : b_delay;
      end

      RVALID = r_pend && (r_wait == 0);
      RDATA  = RVALID ? smem[s_araddr[9:2]] : 32'h0;
      RRESP  = RVALID ? slv_resp : 2'b00;
      if (RVALID && RREADY) r_pend = 1'b0;
      else if (r_pend && r_wait > 0) r_wait--;

      if (ARVALID && !r_pend && ar_hold > 0) begin ARREADY = 1'b0; ar_hold--; end
      else ARREADY = coin();
      if (ARVALID && ARREADY) begin
        s_araddr = ARADDR; ar_hs_n++; r_pend = 1'b1;
        r_wait = rnd ? int'($urandom_range(0, 2)) : r_delay;
      end
    end
  end

  // ---------------- scoring ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain address rules over a sparse word memory
  logic [31:0] ref_mem [int];
  int exp_wr = 0, exp_rd = 0;

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] erd, output logic [1:0] err);
    int word;
    erd  = 32'h0;
    word = int'(a / 4);
    if (a % 4 != 0)       err = 2'b10;
    else if (a >= 1024)   err = 2'b11;
    else begin
      err = 2'b00;
      if (w) begin ref_mem[word] = d; exp_wr++; end
      else begin erd = ref_mem.exists(word) ? ref_mem[word] : 32'h0; exp_rd++; end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic accept_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin @(negedge ACLK); n++; end
    check("accept_ready", 32'(cmd_ready), 32'(1));
    @(negedge ACLK);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  task automatic get_rsp(input int stall, output logic rw, output logic [31:0] rd,
                         output logic [1:0] rr, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge ACLK); lat++; end
    check("rsp_arrives", 32'(rsp_valid), 32'(1));
    rw = rsp_write; rd = rsp_rdata; rr = rsp_resp;
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h104;
      @(negedge ACLK);
      check("hold_rsp_valid", 32'(rsp_valid), 32'(1));
      check("hold_rsp_rdata", rsp_rdata, rd);
      check("hold_rsp_resp", 32'(rsp_resp), 32'(rr));
      check("hold_cmd_ready", 32'(cmd_ready), 32'(0));
    end
    cmd_valid = 1'b0; cmd_addr = '0;
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check("cmd_ready_back", 32'({cmd_ready, rsp_valid}), 32'(2'b10));
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int stall,
                         output logic rw, output logic [31:0] rd, output logic [1:0] rr, output int lat);
    accept_cmd(w, a, d);
    get_rsp(stall, rw, rd, rr, lat);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sresp;
    logic [1:0]  eresp;
    logic [31:0] erdata;
    int          elat;
    int          ewr;
    int          erd;
  } vec_t;

  vec_t vt [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rw;
    logic [31:0] rd, erd, a, d;
    logic [1:0]  rr, err;
    logic        w;
    int          lat, aw0, w0, ar0, wr0, rd0, kind;

    vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        3, 1, 0};
    vt[1]  = '{1'b0, 32'h10,       32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 3, 1, 1};
    vt[2]  = '{1'b1, 32'h3FC,      32'h12345678, 2'b00, 2'b00, 32'h0,        3, 2, 1};
    vt[3]  = '{1'b0, 32'h3FC,      32'h0,        2'b00, 2'b00, 32'h12345678, 3, 2, 2};
    vt[4]  = '{1'b0, 32'h400,      32'h0,        2'b00, 2'b11, 32'h0,        1, 2, 2};
    vt[5]  = '{1'b1, 32'h06,       32'h11111111, 2'b00, 2'b10, 32'h0,        1, 2, 2};
    vt[6]  = '{1'b0, 32'h02,       32'h0,        2'b00, 2'b10, 32'h0,        1, 2, 2};
    vt[7]  = '{1'b0, 32'h401,      32'h0,        2'b00, 2'b10, 32'h0,        1, 2, 2};
    vt[8]  = '{1'b1, 32'hFFFFFFFC, 32'h22222222, 2'b00, 2'b11, 32'h0,        1, 2, 2};
    vt[9]  = '{1'b0, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        3, 2, 3};
    vt[10] = '{1'b1, 32'h40,       32'hCAFEF00D, 2'b10, 2'b10, 32'h0,        3, 3, 3};
    vt[11] = '{1'b0, 32'h44,       32'h0,        2'b11, 2'b11, 32'h0,        3, 3, 4};

    // reset state
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    check("reset_flags", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready}), 32'(0));
    check("reset_addr_data", AWADDR | WDATA | ARADDR, 32'h0);
    check("reset_rsp_fields", rsp_rdata | 32'({rsp_write, rsp_resp}), 32'h0);
    check("reset_counts", 32'({wr_count, rd_count}), 32'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("ready_after_reset", 32'(cmd_ready), 32'(1));

    // table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      slv_resp = vt[i].sresp;
      model(vt[i].w, vt[i].a, vt[i].d, erd, err);
      run_cmd(vt[i].w, vt[i].a, vt[i].d, 0, rw, rd, rr, lat);
      check($sformatf("v%0d_resp", i), 32'(rr), 32'(vt[i].eresp));
      check($sformatf("v%0d_rdata", i), rd, vt[i].erdata);
      check($sformatf("v%0d_write", i), 32'(rw), 32'(vt[i].w));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].elat));
      check($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(vt[i].ewr));
      check($sformatf("v%0d_rd_count", i), 32'(rd_count), 32'(vt[i].erd));
      check($sformatf("v%0d_cnt2", i), 32'({u2_wr_count, u2_rd_count}),
            32'({2'(vt[i].ewr % 4), 2'(vt[i].erd % 4)}));
    end
    slv_resp = 2'b00;
    check("table_aw_handshakes", 32'(aw_hs_n), 32'(3));
    check("table_ar_handshakes", 32'(ar_hs_n), 32'(4));

    // W channel stalled three cycles while AW completes immediately
    w_hold = 3;
    model(1'b1, 32'h20, 32'hA5A5A5A5, erd, err);
    accept_cmd(1'b1, 32'h20, 32'hA5A5A5A5);
    check("stall_c1_valids", 32'({AWVALID, WVALID}), 32'(2'b11));
    check("stall_c1_awaddr", AWADDR, 32'h20);
    @(negedge ACLK);
    check("stall_c2", 32'({AWVALID, WVALID, BREADY}), 32'(3'b010));
    check("stall_c2_wdata", WDATA, 32'hA5A5A5A5);
    @(negedge ACLK);
    check("stall_c3", 32'({AWVALID, WVALID, BREADY}), 32'(3'b010));
    @(negedge ACLK);
    check("stall_c4", 32'({AWVALID, WVALID, BREADY}), 32'(3'b010));
    check("stall_c4_wdata", WDATA, 32'hA5A5A5A5);
    @(negedge ACLK);
    check("stall_c5", 32'({AWVALID, WVALID, BREADY}), 32'(3'b001));
    get_rsp(0, rw, rd, rr, lat);
    check("stall_resp", 32'(rr), 32'(err));

    // response held off for 10 cycles with a competing command pending
    model(1'b0, 32'h20, 32'h0, erd, err);
    run_cmd(1'b0, 32'h20, 32'h0, 10, rw, rd, rr, lat);
    check("bp_rdata", rd, erd);
    check("bp_counts", 32'({wr_count, rd_count}), 32'({16'(exp_wr), 16'(exp_rd)}));

    // reset while waiting for read data
    r_delay = 6;
    accept_cmd(1'b0, 32'h10, 32'h0);
    check("rst_c1_arvalid", 32'(ARVALID), 32'(1));
    @(negedge ACLK);
    check("rst_c2_rready", 32'(RREADY), 32'(1));
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("rst_mid_flags", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy}), 32'(0));
    check("rst_mid_counts", 32'({wr_count, rd_count, u2_wr_count, u2_rd_count}), 32'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    r_delay = 0;
    exp_wr = 0; exp_rd = 0;
    @(negedge ACLK);
    check("rst_ready_again", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 5; i++) begin
      model(1'b1, 32'h80 + 32'(4 * i), 32'h5000 + 32'(i), erd, err);
      run_cmd(1'b1, 32'h80 + 32'(4 * i), 32'h5000 + 32'(i), 0, rw, rd, rr, lat);
      check("post_rst_write_resp", 32'(rr), 32'(err));
    end
    check("five_writes_wr_count", 32'(wr_count), 32'(5));
    check("five_writes_wrap_cnt2", 32'(u2_wr_count), 32'(1));
    model(1'b0, 32'h88, 32'h0, erd, err);
    run_cmd(1'b0, 32'h88, 32'h0, 0, rw, rd, rr, lat);
    check("post_rst_read", rd, erd);

    // randomized commands against the reference model with a jittery slave
    rnd = 1'b1;
    aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n; wr0 = exp_wr; rd0 = exp_rd;
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (kind == 0)      a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'h400 + 32'(4 * $urandom_range(0, 100000));
      else                a = 32'h100 + 32'(4 * $urandom_range(0, 190));
      model(w, a, d, erd, err);
      run_cmd(w, a, d, int'($urandom_range(0, 2)), rw, rd, rr, lat);
      check($sformatf("rnd%0d_resp", i), 32'(rr), 32'(err));
      check($sformatf("rnd%0d_rdata", i), rd, erd);
      check($sformatf("rnd%0d_write", i), 32'(rw), 32'(w));
      if (err[1]) check($sformatf("rnd%0d_local_lat", i), 32'(lat), 32'(1));
      else        check($sformatf("rnd%0d_bus_lat", i), 32'(lat >= 3), 32'(1));
    end
    rnd = 1'b0;
    check("rnd_wr_count", 32'(wr_count), 32'(16'(exp_wr)));
    check("rnd_rd_count", 32'(rd_count), 32'(16'(exp_rd)));
    check("rnd_cnt2", 32'({u2_wr_count, u2_rd_count}), 32'({2'(exp_wr % 4), 2'(exp_rd % 4)}));
    check("rnd_aw_handshakes", 32'(aw_hs_n - aw0), 32'(exp_wr - wr0));
    check("rnd_w_handshakes", 32'(w_hs_n - w0), 32'(exp_wr - wr0));
    check("rnd_ar_handshakes", 32'(ar_hs_n - ar0), 32'(exp_rd - rd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
